// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between two byte sources
// Single registered FSM; all outputs come straight from flops so the tx core sees clean pulses.
module uart_tx_arbiter #(
  parameter int GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       grant,
  output logic       busy
);

  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rr_q;
  logic          tx_start_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [7:0]    tx_data_q;
  logic          grant_q;
  logic          win_d;

  // rr_q holds the last winner; on a tie the other requester goes next.
  always_comb begin
    win_d = req1_valid & (~req0_valid | ~rr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b1;
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_ready && (req0_valid || req1_valid)) begin
            grant_q    <= win_d;
            rr_q       <= win_d;
            tx_data_q  <= win_d ? req1_data : req0_data;
            tx_start_q <= 1'b1;
            ack0_q     <= ~win_d;
            ack1_q     <= win_d;
            state_q    <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!tx_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (GAP == 0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ack = ack0_q;
  assign req1_ack = ack1_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a 10-cycle tx core model
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ack, req1_ack;
  logic       tx_ready, tx_start, grant, busy;
  logic [7:0] tx_data;

  logic       g_req0_valid, g_req1_valid;
  logic [7:0] g_req0_data, g_req1_data;
  logic       g_req0_ack, g_req1_ack;
  logic       g_tx_ready, g_tx_start, g_grant, g_busy;
  logic [7:0] g_tx_data;

  logic tx_ready_m;
  logic ready_en;
  assign tx_ready = tx_ready_m & ready_en;

  uart_tx_arbiter #(.GAP(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ack(req1_ack),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .grant(grant), .busy(busy)
  );

  uart_tx_arbiter #(.GAP(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ack(g_req0_ack),
    .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ack(g_req1_ack),
    .tx_ready(g_tx_ready), .tx_start(g_tx_start), .tx_data(g_tx_data),
    .grant(g_grant), .busy(g_busy)
  );

  typedef struct {
    logic       gr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pushed = 0;
  int n_starts = 0;
  int cyc = 0;
  bit meas_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic expect_byte(input logic gr, input logic [7:0] d);
    exp_t e;
    e.gr = gr;
    e.data = d;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Requesters: present the queue head, advance once an ack has been seen.
  initial begin
    logic a;
    req0_valid = 0;
    req0_data = 8'h00;
    forever begin
      @(negedge clk);
      a = req0_ack;
      @(posedge clk);
      #1;
      if (a && q0.size() > 0) q0.delete(0);
      req0_valid = (q0.size() > 0);
      req0_data = (q0.size() > 0) ? q0[0] : 8'h00;
    end
  end

  initial begin
    logic a;
    req1_valid = 0;
    req1_data = 8'h00;
    forever begin
      @(negedge clk);
      a = req1_ack;
      @(posedge clk);
      #1;
      if (a && q1.size() > 0) q1.delete(0);
      req1_valid = (q1.size() > 0);
      req1_data = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // Tx core: ready drops the cycle after tx_start and stays low for 10 cycles.
  initial begin
    tx_ready_m = 1;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1 tx_ready_m = 0;
        repeat (10) @(posedge clk);
        #1 tx_ready_m = 1;
      end
    end
  end

  // Monitor: every tx_start consumes one expected byte.
  initial begin
    exp_t e;
    bit   prev_ready = 0;
    bit   rise_ok = 0;
    int   rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!meas_en) rise_ok = 0;
      if (!rst) begin
        if (tx_ready && !prev_ready) begin
          rise_cyc = cyc + 1;
          rise_ok = 1;
        end
        if (tx_start) begin
          n_starts++;
          if (exp_q.size() == 0) begin
            chk("unexpected_tx_start", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("grant", grant, e.gr);
            chk("req0_ack", req0_ack, (e.gr == 1'b0));
            chk("req1_ack", req1_ack, (e.gr == 1'b1));
          end
          if (meas_en && rise_ok) chk("gap_cycles", cyc - rise_cyc, 17);
          rise_ok = 0;
        end else if (req0_ack || req1_ack) begin
          chk("ack_without_start", 1, 0);
        end
      end
      prev_ready = tx_ready;
    end
  end

  task automatic wait_start(input string nm, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk(nm, 0, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy && tx_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) chk(nm, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    ready_en = 1;
    g_req0_valid = 0; g_req0_data = 8'h00;
    g_req1_valid = 0; g_req1_data = 8'h00;
    g_tx_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_acks", {req0_ack, req1_ack}, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 0);
    rst = 0;

    // 1: single request, one-cycle decision latency, one-cycle pulses
    @(negedge clk);
    q0.push_back(8'h48);
    expect_byte(1'b0, 8'h48);
    @(negedge clk);
    chk("t1_no_start_yet", tx_start, 0);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    @(negedge clk);
    chk("t1_start_one_cycle", tx_start, 0);
    chk("t1_ack_one_cycle", req0_ack, 0);
    chk("t1_data_held", tx_data, 8'h48);
    wait_idle("t1_timeout", 200);

    // 2+3: both continuously valid, alternating order, 17-cycle rise-to-start
    do_reset();
    @(negedge clk);
    meas_en = 1;
    q0.push_back(8'h41); q0.push_back(8'h41);
    q1.push_back(8'h42); q1.push_back(8'h42);
    expect_byte(1'b0, 8'h41);
    expect_byte(1'b1, 8'h42);
    expect_byte(1'b0, 8'h41);
    expect_byte(1'b1, 8'h42);
    wait_idle("t2_timeout", 400);
    meas_en = 0;

    // 4: request while tx core not ready waits, then starts next cycle
    @(negedge clk);
    ready_en = 0;
    q1.push_back(8'h99);
    expect_byte(1'b1, 8'h99);
    repeat (6) @(negedge clk);
    chk("t4_still_idle", busy, 0);
    ready_en = 1;
    @(negedge clk);
    chk("t4_start_next_cycle", tx_start, 1);
    wait_idle("t4_timeout", 200);

    // 5: reset during WAIT_DONE, then req0 wins the tie
    @(negedge clk);
    q1.push_back(8'h31);
    expect_byte(1'b1, 8'h31);
    wait_start("t5_start_timeout", 20);
    repeat (4) @(negedge clk);
    chk("t5_in_flight", {busy, tx_ready}, 2'b10);
    rst = 1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_tx_start", tx_start, 0);
    chk("t5_acks", {req0_ack, req1_ack}, 0);
    chk("t5_tx_data", tx_data, 8'h00);
    chk("t5_grant", grant, 0);
    rst = 0;
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    expect_byte(1'b0, 8'h11);
    expect_byte(1'b1, 8'h22);
    wait_idle("t5_timeout", 300);

    // 6: req0 withdrawn while tx busy -> never acked, never sent
    @(negedge clk);
    q1.push_back(8'h60);
    expect_byte(1'b1, 8'h60);
    wait_start("t6_start_timeout", 20);
    repeat (3) @(negedge clk);
    q0.push_back(8'h70);
    repeat (4) @(negedge clk);
    q0.delete();
    wait_idle("t6_timeout", 200);
    repeat (40) @(negedge clk);
    chk("t6_stays_idle", busy, 0);
    chk("starts_total", n_starts, n_pushed);

    // 3b: GAP=0 build, tx_ready rise to tx_start is 1 cycle
    @(posedge clk);
    #1;
    g_tx_ready = 1;
    g_req0_valid = 1;
    g_req0_data = 8'h77;
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (g_tx_start) begin
          seen = 1;
          break;
        end
      end
      chk("g0_first_start", seen, 1);
    end
    chk("g0_first_data", g_tx_data, 8'h77);
    @(posedge clk);
    #1;
    g_req0_valid = 0;
    g_tx_ready = 0;
    g_req1_valid = 1;
    g_req1_data = 8'h88;
    repeat (3) @(posedge clk);
    #1 g_tx_ready = 1;
    @(negedge clk);
    chk("g0_not_yet", g_tx_start, 0);
    @(negedge clk);
    chk("g0_idle_after_done", {g_busy, g_tx_start}, 2'b00);
    @(negedge clk);
    chk("g0_start_1_cycle", g_tx_start, 1);
    chk("g0_data", g_tx_data, 8'h88);
    chk("g0_grant_ack", {g_grant, g_req1_ack, g_req0_ack}, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
